paddsb_serial_ctrl: RTL

Sequenced, area-reduced implementation of the packed saturating add (PADDSB): one shared 4-bit saturating lane adder is time-multiplexed across the four nibble lanes of a 16-bit operand pair. A small FSM latches the operands, steps a lane counter, and assembles the result. A start/ready/done handshake lets the execute-stage control hold the pipeline while the operation runs. Results are bit-identical to the combinational packed adder, plus per-lane saturation flags.

---
 rtl/paddsb_pkg.sv | 20 ++
 rtl/paddsb_serial_ctrl_if.sv | 17 +
 rtl/paddsb_serial_ctrl_sat_lane_add.sv | 27 ++
 rtl/paddsb_serial_ctrl.sv | 104 ++++++++++
 4 files changed

// File: rtl/paddsb_pkg.sv
// Shared types and constants for the serial packed saturating adder.
// Lane geometry, clamp values and controller states live here.
package paddsb_pkg;

  localparam int LANE_W    = 4;
  localparam int NUM_LANES = 4;
  localparam int DATA_W    = LANE_W * NUM_LANES;

  localparam logic [LANE_W-1:0] SAT_POS = 4'b0111;
  localparam logic [LANE_W-1:0] SAT_NEG = 4'b1000;

  localparam logic [1:0] LAST_LANE = 2'(NUM_LANES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/paddsb_serial_ctrl_if.sv
// Handshake and data bundle between execute-stage control and the serial adder.
// The requester drives start/a/b and the adder returns ready/done/sum/sat.
interface paddsb_serial_ctrl_if;
  import paddsb_pkg::*;

  logic                 start;
  logic [DATA_W-1:0]    a;
  logic [DATA_W-1:0]    b;
  logic                 ready;
  logic                 done;
  logic [DATA_W-1:0]    sum;
  logic [NUM_LANES-1:0] sat;

  modport master (output start, a, b, input ready, done, sum, sat);
  modport slave  (input start, a, b, output ready, done, sum, sat);

endinterface

// File: rtl/paddsb_serial_ctrl_sat_lane_add.sv
// Combinational 4-bit two's complement adder that clamps on signed overflow.
// Overflow is only possible when both operands share a sign bit.
module sat_lane_add
  import paddsb_pkg::*;
(
  input  logic [LANE_W-1:0] x,
  input  logic [LANE_W-1:0] y,
  output logic [LANE_W-1:0] r,
  output logic              sat
);

  logic [LANE_W-1:0] w_raw;

  always_comb begin
    w_raw = x + y;
    r     = w_raw;
    sat   = 1'b0;
    if (!x[LANE_W-1] && !y[LANE_W-1] && w_raw[LANE_W-1]) begin
      r   = SAT_POS;
      sat = 1'b1;
    end else if (x[LANE_W-1] && y[LANE_W-1] && !w_raw[LANE_W-1]) begin
      r   = SAT_NEG;
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/paddsb_serial_ctrl.sv
// Sequenced PADDSB: one shared saturating lane adder walks the four nibble lanes,
// with sum/sat published only once all lanes are complete.
module paddsb_serial_ctrl
  import paddsb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  paddsb_serial_ctrl_if.slave  bus
);

  state_t               r_state;
  state_t               w_nextState;
  logic [1:0]           r_lane;
  logic [DATA_W-1:0]    r_aQ;
  logic [DATA_W-1:0]    r_bQ;
  logic [DATA_W-1:0]    r_accQ;
  logic [NUM_LANES-1:0] r_flagQ;
  logic [DATA_W-1:0]    r_sum;
  logic [NUM_LANES-1:0] r_sat;

  logic                 w_accept;
  logic [LANE_W-1:0]    w_x;
  logic [LANE_W-1:0]    w_y;
  logic [LANE_W-1:0]    w_r;
  logic                 w_laneSat;
  logic [DATA_W-1:0]    w_accNext;
  logic [NUM_LANES-1:0] w_flagNext;

  assign w_accept = bus.start && (r_state == IDLE || r_state == DONE);

  assign w_x = r_aQ[r_lane*LANE_W +: LANE_W];
  assign w_y = r_bQ[r_lane*LANE_W +: LANE_W];

  sat_lane_add u_laneAdd (
    .x   (w_x),
    .y   (w_y),
    .r   (w_r),
    .sat (w_laneSat)
  );

  // Merge this cycle's lane into the working registers so the final lane is
  // already included when the result is published.
  always_comb begin
    w_accNext          = r_accQ;
    w_accNext[r_lane*LANE_W +: LANE_W] = w_r;
    w_flagNext         = r_flagQ;
    w_flagNext[r_lane] = w_laneSat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_nextState = RUN;
      RUN:     if (r_lane == LAST_LANE) w_nextState = DONE;
      DONE:    w_nextState = bus.start ? RUN : IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    bus.ready = (r_state == IDLE) || (r_state == DONE);
    bus.done  = (r_state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lane  <= 2'd0;
      r_aQ    <= '0;
      r_bQ    <= '0;
      r_accQ  <= '0;
      r_flagQ <= '0;
      r_sum   <= '0;
      r_sat   <= '0;
    end else if (w_accept) begin
      r_lane  <= 2'd0;
      r_aQ    <= bus.a;
      r_bQ    <= bus.b;
      r_accQ  <= '0;
      r_flagQ <= '0;
    end else if (r_state == RUN) begin
      r_accQ  <= w_accNext;
      r_flagQ <= w_flagNext;
      if (r_lane == LAST_LANE) begin
        r_lane <= 2'd0;
        r_sum  <= w_accNext;
        r_sat  <= w_flagNext;
      end else begin
        r_lane <= r_lane + 2'd1;
      end
    end
  end

  assign bus.sum = r_sum;
  assign bus.sat = r_sat;

endmodule
